// File: rtl/bsh_pkg.sv
// bsh_pkg: shared constants and types for the bsh_32 barrel shifter.
//   BSH_WIDTH / BSH_SH_W : default data width and shift-amount width
//   DIR_LEFT / DIR_RIGHT : encodings of the dir port
//   bsh_word_t           : one data word
package bsh_pkg;

  localparam int unsigned BSH_WIDTH = 32;
  localparam int unsigned BSH_SH_W  = 5;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  typedef logic [BSH_WIDTH-1:0] bsh_word_t;

endpackage

// File: rtl/bsh_stage.sv
// bsh_stage: one stage of the logarithmic shift network. When en is high the
// word moves left by DIST positions, otherwise it passes through unchanged.
// Build option BSH_ROTATE_EN: bits leaving the MSB end re-enter at the LSB end
// (rotate); without it the vacated LSBs are zero-filled.
// Ports:
//   en_i   : apply this stage's shift
//   data_i : word from the previous stage
//   data_o : word to the next stage
module bsh_stage
  import bsh_pkg::*;
#(
  parameter int unsigned WIDTH = BSH_WIDTH,
  parameter int unsigned DIST  = 1
) (
  input  logic             en_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o
);

  always_comb begin
    data_o = data_i;
    if (en_i) begin
`ifdef BSH_ROTATE_EN
      data_o = {data_i[WIDTH-DIST-1:0], data_i[WIDTH-1:WIDTH-DIST]};
`else
      data_o = {data_i[WIDTH-DIST-1:0], {DIST{1'b0}}};
`endif
    end
  end

endmodule

// File: rtl/bsh_32.sv
// bsh_32: 32-bit logarithmic barrel shifter with a registered output and
// one cycle of latency. A new result is produced on every clock edge.
// Build option BSH_ROTATE_EN turns the logical shifts into rotations.
// Ports:
//   clk      : rising-edge clock
//   rst      : synchronous reset, active-high; clears data_out
//   data_in  : operand to shift
//   dir      : 0 = shift left, 1 = shift right
//   sh       : shift amount, 0..WIDTH-1
//   data_out : registered shifted result
module bsh_32
  import bsh_pkg::*;
#(
  parameter int unsigned WIDTH = BSH_WIDTH,
  parameter int unsigned SH_W  = BSH_SH_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             dir,
  input  logic [SH_W-1:0]  sh,
  output logic [WIDTH-1:0] data_out
);

  logic [WIDTH-1:0] rev_in;
  logic [WIDTH-1:0] net_in;
  logic [WIDTH-1:0] net_out;
  logic [WIDTH-1:0] rev_out;
  logic [WIDTH-1:0] chain [SH_W+1];
  logic [WIDTH-1:0] data_out_d;
  logic [WIDTH-1:0] data_out_q;

  // A right shift/rotate is a left one performed on the bit-reversed word,
  // so only a single left-going network is needed.
  always_comb begin
    rev_in = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      rev_in[i] = data_in[WIDTH-1-i];
    end
  end

  assign net_in   = (dir == DIR_RIGHT) ? rev_in : data_in;
  assign chain[0] = net_in;

  for (genvar k = 0; k < SH_W; k++) begin : g_stage
    bsh_stage #(
      .WIDTH (WIDTH),
      .DIST  (1 << k)
    ) u_stage (
      .en_i   (sh[k]),
      .data_i (chain[k]),
      .data_o (chain[k+1])
    );
  end

  assign net_out = chain[SH_W];

  always_comb begin
    rev_out = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      rev_out[i] = net_out[WIDTH-1-i];
    end
  end

  assign data_out_d = (dir == DIR_RIGHT) ? rev_out : net_out;

  always_ff @(posedge clk) begin
    if (rst) begin
      data_out_q <= '0;
    end else begin
      data_out_q <= data_out_d;
    end
  end

  assign data_out = data_out_q;

endmodule

// File: tb/tb_bsh_32.sv
// tb_bsh_32: directed self-checking bench for bsh_32 (either build of
// BSH_ROTATE_EN; expectations follow the same macro).
module tb_bsh_32;
  import bsh_pkg::*;

  logic       clk;
  logic       rst;
  bsh_word_t  data_in;
  logic       dir;
  logic [4:0] sh;
  bsh_word_t  data_out;

  int checks = 0;
  int errors = 0;

  bsh_32 #(.WIDTH(32), .SH_W(5)) dut (
    .clk      (clk),
    .rst      (rst),
    .data_in  (data_in),
    .dir      (dir),
    .sh       (sh),
    .data_out (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bsh_word_t ref_shift(bsh_word_t d, logic r, logic [4:0] s);
`ifdef BSH_ROTATE_EN
    if (s == 5'd0) return d;
    if (r == DIR_LEFT) return (d << s) | (d >> (32 - s));
    return (d >> s) | (d << (32 - s));
`else
    if (r == DIR_LEFT) return d << s;
    return d >> s;
`endif
  endfunction

  task automatic check(input string tag, input bsh_word_t obs, input bsh_word_t exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Apply inputs, let one rising edge capture them, then sample 1 time unit later.
  task automatic step(input logic r, input bsh_word_t d, input logic dr, input logic [4:0] s);
    rst     = r;
    data_in = d;
    dir     = dr;
    sh      = s;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bsh_word_t exp_w;
    bsh_word_t rd;
    logic [4:0] rs;
    logic rdir;

    rst = 1'b1; data_in = '0; dir = DIR_LEFT; sh = '0;

    step(1'b1, 32'hFFFF_FFFF, DIR_LEFT, 5'd5);
    check("reset_c1", data_out, 32'h0000_0000);
    step(1'b1, 32'hFFFF_FFFF, DIR_RIGHT, 5'd5);
    check("reset_c2", data_out, 32'h0000_0000);

    step(1'b0, 32'h0000_00F1, DIR_LEFT, 5'd4);
    check("left_f1_4", data_out, 32'h0000_0F10);

`ifdef BSH_ROTATE_EN
    step(1'b0, 32'h8000_0001, DIR_RIGHT, 5'd31);
    check("right_31", data_out, 32'h0000_0003);
    step(1'b0, 32'h8000_0001, DIR_LEFT, 5'd31);
    check("left_31", data_out, 32'hC000_0000);
    step(1'b0, 32'h8000_0001, DIR_LEFT, 5'd1);
    check("rot_left_1", data_out, 32'h0000_0003);
    step(1'b0, 32'h8000_0001, DIR_RIGHT, 5'd1);
    check("rot_right_1", data_out, 32'hC000_0000);
    step(1'b0, 32'h1234_5678, DIR_LEFT, 5'd8);
    check("left_8", data_out, 32'h3456_7812);
    step(1'b0, 32'h1234_5678, DIR_RIGHT, 5'd8);
    check("right_8", data_out, 32'h7812_3456);
`else
    step(1'b0, 32'h8000_0001, DIR_RIGHT, 5'd31);
    check("right_31", data_out, 32'h0000_0001);
    step(1'b0, 32'h8000_0001, DIR_LEFT, 5'd31);
    check("left_31", data_out, 32'h8000_0000);
    step(1'b0, 32'h8000_0001, DIR_LEFT, 5'd1);
    check("left_1", data_out, 32'h0000_0002);
    step(1'b0, 32'h8000_0001, DIR_RIGHT, 5'd1);
    check("right_1", data_out, 32'h4000_0000);
    step(1'b0, 32'h1234_5678, DIR_LEFT, 5'd8);
    check("left_8", data_out, 32'h3456_7800);
    step(1'b0, 32'h1234_5678, DIR_RIGHT, 5'd8);
    check("right_8", data_out, 32'h0012_3456);
`endif

    step(1'b0, 32'hF000_0000, DIR_RIGHT, 5'd16);
    check("right_16", data_out, 32'h0000_F000);

    step(1'b0, 32'hDEAD_BEEF, DIR_LEFT, 5'd0);
    check("ident_left", data_out, 32'hDEAD_BEEF);
    step(1'b0, 32'hDEAD_BEEF, DIR_RIGHT, 5'd0);
    check("ident_right", data_out, 32'hDEAD_BEEF);

    // Mid-stream reset, then the first edge after release carries live data.
    step(1'b1, 32'hDEAD_BEEF, DIR_RIGHT, 5'd3);
    check("mid_reset", data_out, 32'h0000_0000);
    step(1'b0, 32'hDEAD_BEEF, DIR_RIGHT, 5'd4);
    check("post_reset", data_out, ref_shift(32'hDEAD_BEEF, DIR_RIGHT, 5'd4));

    rdir = DIR_LEFT;
    for (int i = 0; i < 10; i++) begin
      rd    = $urandom;
      rs    = 5'($urandom_range(0, 31));
      exp_w = ref_shift(rd, rdir, rs);
      step(1'b0, rd, rdir, rs);
      check($sformatf("b2b_%0d", i), data_out, exp_w);
      rdir = ~rdir;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
